// File: rtl/fft_frame_feeder_if.sv
// rtl/fft_frame_feeder_if.sv - serial sample stream in, lane-parallel FFT beats out
interface fft_frame_feeder_if #(
   parameter int WIDTH = 9,
   parameter int LANES = 16
);
   logic                    s_valid;
   logic                    s_ready;
   logic signed [WIDTH-1:0] s_i;
   logic signed [WIDTH-1:0] s_q;
   logic                    s_last;
   logic signed [WIDTH-1:0] din_i [0:LANES-1];
   logic signed [WIDTH-1:0] din_q [0:LANES-1];
   logic                    din_valid;
   logic                    frame_err;

   // Sample producer / FFT consumer side
   modport master (
      output s_valid, s_i, s_q, s_last,
      input  s_ready, din_i, din_q, din_valid, frame_err
   );

   // Feeder side
   modport slave (
      input  s_valid, s_i, s_q, s_last,
      output s_ready, din_i, din_q, din_valid, frame_err
   );
endinterface

// File: rtl/fft_frame_feeder.sv
// rtl/fft_frame_feeder.sv - ping-pong framer feeding 512-point FFT with gap-free 16-lane bursts; FFT_FEEDER_ERR_CNT_EN adds err_cnt
module fft_frame_feeder #(
   parameter int WIDTH    = 9,
   parameter int N        = 512,
   parameter int LANES    = 16,
   parameter int LANE_MAP = 0
) (
   input  logic              clk,
   input  logic              rst,
   fft_frame_feeder_if.slave io
`ifdef FFT_FEEDER_ERR_CNT_EN
   ,
   output logic [15:0]       err_cnt
`endif
);
   localparam int DEPTH  = N / LANES;
   localparam int CNT_W  = $clog2(N);
   localparam int LANE_W = $clog2(LANES);
   localparam int ADDR_W = $clog2(DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE,
      ST_BURST
   } state_t;

   // Two banks x LANES lane memories x DEPTH words of {i,q}
   logic [2*WIDTH-1:0] mem [0:1][0:LANES-1][0:DEPTH-1];

   logic [CNT_W-1:0]  wr_cnt;
   logic              wr_bank;
   logic              rd_bank;
   logic              rd_bank_nxt;
   logic [1:0]        full;
   logic [ADDR_W-1:0] beat;
   logic [ADDR_W-1:0] beat_nxt;
   state_t            state;
   state_t            state_nxt;

   logic              ready_int;
   logic              accept;
   logic              at_end;
   logic              framing_bad;
   logic              store;
   logic              set_full;
   logic              clr_full;
   logic              rd_issue;
   logic              frame_err_r;
   logic              din_valid_r;
   logic [LANE_W-1:0] wr_lane;
   logic [ADDR_W-1:0] wr_addr;

   logic signed [WIDTH-1:0] din_i_r [0:LANES-1];
   logic signed [WIDTH-1:0] din_q_r [0:LANES-1];

   // Sample placement inside a bank depends on the selected lane ordering
   generate
      if (LANE_MAP == 0) begin : g_seq
         assign wr_lane = wr_cnt[LANE_W-1:0];
         assign wr_addr = wr_cnt[CNT_W-1:LANE_W];
      end else begin : g_strided
         assign wr_addr = wr_cnt[ADDR_W-1:0];
         assign wr_lane = wr_cnt[CNT_W-1:ADDR_W];
      end
   endgenerate

   // Input handshake and frame-boundary decode
   assign ready_int   = !rst && !full[wr_bank];
   assign accept      = io.s_valid && ready_int;
   assign at_end      = (wr_cnt == CNT_W'(N - 1));
   assign framing_bad = accept && (io.s_last != at_end);
   assign store       = accept && !framing_bad;
   assign set_full    = store && at_end;

   assign io.s_ready   = ready_int;
   assign io.frame_err = frame_err_r;
   assign io.din_valid = din_valid_r;
   assign io.din_i     = din_i_r;
   assign io.din_q     = din_q_r;

   // Write counter, write bank select and framing-error pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt      <= '0;
         wr_bank     <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         frame_err_r <= framing_bad;
         if (framing_bad) begin
            // partial frame is abandoned; the same bank is refilled from sample 0
            wr_cnt <= '0;
         end else if (store) begin
            if (at_end) begin
               wr_cnt  <= '0;
               wr_bank <= ~wr_bank;
            end else begin
               wr_cnt <= wr_cnt + CNT_W'(1);
            end
         end
      end
   end

   // Lane memory write port (contents need no reset: full flags gate their use)
   always_ff @(posedge clk) begin
      if (store) begin
         mem[wr_bank][wr_lane][wr_addr] <= {io.s_i, io.s_q};
      end
   end

   // Bank-full flags: writer sets its bank, reader clears its bank independently
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 2'b00;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (set_full && (wr_bank == 1'(b))) begin
               full[b] <= 1'b1;
            end else if (clr_full && (rd_bank == 1'(b))) begin
               full[b] <= 1'b0;
            end
         end
      end
   end

   // Read FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         beat    <= '0;
         rd_bank <= 1'b0;
      end else begin
         state   <= state_nxt;
         beat    <= beat_nxt;
         rd_bank <= rd_bank_nxt;
      end
   end

   // Read FSM next state: one burst of DEPTH beats per full bank, one idle cycle between
   always_comb begin
      state_nxt   = state;
      beat_nxt    = beat;
      rd_bank_nxt = rd_bank;
      clr_full    = 1'b0;
      rd_issue    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (full[rd_bank]) begin
               state_nxt = ST_BURST;
               beat_nxt  = '0;
            end
         end
         ST_BURST: begin
            rd_issue = 1'b1;
            beat_nxt = beat + ADDR_W'(1);
            if (beat == ADDR_W'(DEPTH - 1)) begin
               clr_full    = 1'b1;
               rd_bank_nxt = ~rd_bank;
               state_nxt   = ST_IDLE;
               beat_nxt    = '0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Output beat register: lane data holds its last value outside a burst
   always_ff @(posedge clk) begin
      if (rst) begin
         din_valid_r <= 1'b0;
         for (int l = 0; l < LANES; l++) begin
            din_i_r[l] <= '0;
            din_q_r[l] <= '0;
         end
      end else begin
         din_valid_r <= rd_issue;
         if (rd_issue) begin
            for (int l = 0; l < LANES; l++) begin
               {din_i_r[l], din_q_r[l]} <= mem[rd_bank][l][beat];
            end
         end
      end
   end

`ifdef FFT_FEEDER_ERR_CNT_EN
   // Saturating count of dropped frames, rising together with frame_err
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (framing_bad && (err_cnt != 16'hFFFF)) begin
         err_cnt <= err_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb/tb_fft_frame_feeder.sv - randomized frame-level check of fft_frame_feeder, both lane maps; FFT_FEEDER_ERR_CNT_EN aware
`timescale 1ns/1ps
module tb_fft_frame_feeder;
   localparam int W     = 9;
   localparam int N     = 512;
   localparam int L     = 16;
   localparam int D     = N / L;
   localparam int NSLOT = 16;

   typedef logic signed [W-1:0] lane_t [0:L-1];

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic                s_valid = 1'b0;
   logic                s_last  = 1'b0;
   logic signed [W-1:0] s_i     = '0;
   logic signed [W-1:0] s_q     = '0;

   fft_frame_feeder_if #(.WIDTH(W), .LANES(L)) if0 ();
   fft_frame_feeder_if #(.WIDTH(W), .LANES(L)) if1 ();

   assign if0.s_valid = s_valid;
   assign if0.s_last  = s_last;
   assign if0.s_i     = s_i;
   assign if0.s_q     = s_q;
   assign if1.s_valid = s_valid;
   assign if1.s_last  = s_last;
   assign if1.s_i     = s_i;
   assign if1.s_q     = s_q;

`ifdef FFT_FEEDER_ERR_CNT_EN
   logic [15:0] err_cnt0;
   logic [15:0] err_cnt1;
`endif

   fft_frame_feeder #(.WIDTH(W), .N(N), .LANES(L), .LANE_MAP(0)) dut0 (
      .clk(clk),
      .rst(rst),
      .io(if0)
`ifdef FFT_FEEDER_ERR_CNT_EN
      , .err_cnt(err_cnt0)
`endif
   );

   fft_frame_feeder #(.WIDTH(W), .N(N), .LANES(L), .LANE_MAP(1)) dut1 (
      .clk(clk),
      .rst(rst),
      .io(if1)
`ifdef FFT_FEEDER_ERR_CNT_EN
      , .err_cnt(err_cnt1)
`endif
   );

   // Reference model: completed frames kept in sample order, per-map read pointers
   logic [2*W-1:0] fbuf [0:NSLOT-1][0:N-1];
   int             lat [0:NSLOT-1];
   int             nf = 0;
   int             rf [0:1] = '{0, 0};
   int             bcnt [0:1] = '{0, 0};
   int             cur_cnt = 0;
   int             cyc = 0;
   int             errs = 0;
   int             errs_rst = 0;
   int             fe_seen = 0;
   logic           acc_next = 1'b0;
   logic           exp_ferr = 1'b0;
   logic           rst_seen = 1'b0;
   int             total = 0;
   int             bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   task automatic mon_beat(input int m, input logic dv, input lane_t di, input lane_t dq);
      int slot;
      int k;
      if (dv) begin
         if (rf[m] == nf) begin
            check($sformatf("spurious_beat m%0d", m), dv, 1'b0);
            return;
         end
         slot = rf[m] % NSLOT;
         if (m == 0 && bcnt[m] == 0 && lat[slot] >= 0)
            check("first_beat_latency", cyc, lat[slot]);
         for (int l = 0; l < L; l++) begin
            k = (m == 0) ? (bcnt[m] * L + l) : (l * D + bcnt[m]);
            check($sformatf("data m%0d f%0d b%0d l%0d", m, rf[m], bcnt[m], l),
                  {14'd0, di[l], dq[l]}, {14'd0, fbuf[slot][k]});
         end
         bcnt[m]++;
         if (bcnt[m] == D) begin
            bcnt[m] = 0;
            rf[m]++;
         end
      end else if (bcnt[m] != 0) begin
         check($sformatf("burst_gap m%0d", m), dv, 1'b1);
         bcnt[m] = 0;
         rf[m]++;
      end
   endtask

   // Sample DUT outputs between edges, then advance the model over the coming edge
   always @(negedge clk) begin : monitor
      logic exp_rdy;
      int   slot;
      if (rst_seen) begin
         check("rst_din_valid0", if0.din_valid, 1'b0);
         check("rst_din_valid1", if1.din_valid, 1'b0);
         check("rst_frame_err", if0.frame_err, 1'b0);
         check("rst_din_i0", if0.din_i[0], '0);
         check("rst_din_q_last", if1.din_q[L-1], '0);
      end else begin
         mon_beat(0, if0.din_valid, if0.din_i, if0.din_q);
         mon_beat(1, if1.din_valid, if1.din_i, if1.din_q);
         check("frame_err0", if0.frame_err, exp_ferr);
         check("frame_err1", if1.frame_err, exp_ferr);
         if (if0.frame_err) fe_seen++;
      end
      exp_rdy = !rst && ((nf - rf[0]) < 2);
      check("s_ready0", if0.s_ready, exp_rdy);
      check("s_ready1", if1.s_ready, exp_rdy);

      exp_ferr = 1'b0;
      acc_next = 1'b0;
      if (rst) begin
         rf[0]    = nf;
         rf[1]    = nf;
         bcnt[0]  = 0;
         bcnt[1]  = 0;
         cur_cnt  = 0;
         errs_rst = 0;
         rst_seen = 1'b1;
      end else begin
         rst_seen = 1'b0;
         acc_next = s_valid && exp_rdy;
         if (acc_next) begin
            if (s_last != (cur_cnt == N - 1)) begin
               exp_ferr = 1'b1;
               errs++;
               errs_rst++;
               cur_cnt = 0;
            end else begin
               slot = nf % NSLOT;
               fbuf[slot][cur_cnt] = {s_i, s_q};
               if (cur_cnt == N - 1) begin
                  lat[slot] = (nf == rf[0]) ? cyc + 3 : -1;
                  nf++;
                  cur_cnt = 0;
               end else begin
                  cur_cnt++;
               end
            end
         end
      end
   end

   task automatic send(input logic signed [W-1:0] vi, input logic signed [W-1:0] vq, input logic lst);
      int n;
      s_valid = 1'b1;
      s_i     = vi;
      s_q     = vq;
      s_last  = lst;
      n = 0;
      forever begin
         @(posedge clk);
         if (acc_next) break;
         n++;
         if (n > 4000) begin
            check("accept_timeout", acc_next, 1'b1);
            break;
         end
      end
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // kind 0: ramp i=k-256, q=-k; kind 1: random. err_at>=0 flips s_last there and abandons the frame.
   task automatic send_frame(input int kind, input int err_at, input int gap_pct);
      for (int k = 0; k < N; k++) begin
         logic signed [W-1:0] vi;
         logic signed [W-1:0] vq;
         logic                lst;
         if (kind == 0) begin
            vi = W'(k - 256);
            vq = W'(-k);
         end else begin
            vi = W'($urandom);
            vq = W'($urandom);
         end
         lst = (k == N - 1);
         if (k == err_at) begin
            send(vi, vq, !lst);
            return;
         end
         send(vi, vq, lst);
         if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((rf[0] != nf || rf[1] != nf) && n < 3000) begin
         @(posedge clk);
         n++;
      end
      check("drain_timeout", n < 3000, 1'b1);
      idle(3);
   endtask

   initial begin : stim
      int n;
      idle(4);
      rst = 1'b0;
      idle(2);

      // single ramp frame
      send_frame(0, -1, 0);
      drain();

      // three frames back to back at one sample per clock
      send_frame(1, -1, 0);
      send_frame(1, -1, 0);
      send_frame(1, -1, 0);
      drain();

      // early s_last at k=100, then a clean frame
      send_frame(0, 100, 0);
      send_frame(1, -1, 0);
      drain();
      check("frame_err_pulses_after_early_last", fe_seen, 1);
`ifdef FFT_FEEDER_ERR_CNT_EN
      check("err_cnt0_one", err_cnt0, 16'd1);
      check("err_cnt1_one", err_cnt1, 16'd1);
`endif

      // missing s_last at k=511, then random frames with input gaps
      send_frame(1, N - 1, 0);
      send_frame(1, -1, 20);
      send_frame(1, $urandom_range(0, N - 2), 10);
      send_frame(1, -1, 20);
      send_frame(1, -1, 0);
      drain();
`ifdef FFT_FEEDER_ERR_CNT_EN
      check("err_cnt0", err_cnt0, errs_rst);
      check("err_cnt1", err_cnt1, errs_rst);
`endif

      // reset in the middle of a burst
      send_frame(1, -1, 0);
      n = 0;
      while (bcnt[0] < 10 && n < 200) begin
         @(posedge clk);
         n++;
      end
      check("reach_beat10", n < 200, 1'b1);
      #1;
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(40);
      send_frame(1, -1, 0);
      drain();

      check("frame_err_total", fe_seen, errs);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
